// File: rtl/uart_tx_arbiter.sv
// Two-requester packet arbiter in front of a single UART TX byte path.
// Optional idle-owner timeout release: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_W          = 24
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       kbd_valid,
  input  logic [7:0] kbd_data,
  input  logic       kbd_last,
  output logic       kbd_ready,
  input  logic       rsp_valid,
  input  logic [7:0] rsp_data,
  input  logic       rsp_last,
  output logic       rsp_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic [1:0] grant,
  output logic       abort
);

  if (64'(TIMEOUT_CYCLES) >= (64'd1 << CNT_W)) begin : g_cfg_err
    $error("TIMEOUT_CYCLES must be below 2**CNT_W");
  end

  typedef enum logic {S_IDLE, S_LOCKED} state_e;

  state_e     state_q, state_d;
  logic       owner_q, owner_d;
  logic       rr_last_q, rr_last_d;
  logic       tx_valid_q;
  logic [7:0] tx_data_q;
  logic [1:0] sync_q;
  logic       rst_sync_n;

  logic       locked;
  logic       room;
  logic       own_valid;
  logic       own_last;
  logic [7:0] own_data;
  logic       xfer;
  logic       timeout_hit;

  // Assert asynchronously, release two edges after rst_n rises.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], 1'b1};
  end

  assign rst_sync_n = sync_q[1];

  assign locked    = (state_q == S_LOCKED);
  assign room      = !tx_valid_q || tx_ready;
  assign own_valid = owner_q ? rsp_valid : kbd_valid;
  assign own_last  = owner_q ? rsp_last  : kbd_last;
  assign own_data  = owner_q ? rsp_data  : kbd_data;
  assign xfer      = locked && own_valid && room;

  always_ff @(posedge clk_sys or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      rr_last_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    unique case (state_q)
      S_IDLE: begin
        if (kbd_valid && rsp_valid) begin
          state_d = S_LOCKED;
          owner_d = !rr_last_q;
        end else if (kbd_valid) begin
          state_d = S_LOCKED;
          owner_d = 1'b0;
        end else if (rsp_valid) begin
          state_d = S_LOCKED;
          owner_d = 1'b1;
        end
      end
      S_LOCKED: begin
        if ((xfer && own_last) || timeout_hit) begin
          state_d   = S_IDLE;
          rr_last_d = owner_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant     = 2'b00;
    kbd_ready = 1'b0;
    rsp_ready = 1'b0;
    if (locked) begin
      grant     = owner_q ? 2'b10 : 2'b01;
      kbd_ready = !owner_q && room;
      rsp_ready = owner_q && room;
    end
  end

  // One-entry output register; a new byte may replace a departing one.
  always_ff @(posedge clk_sys or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else if (xfer) begin
      tx_valid_q <= 1'b1;
      tx_data_q  <= own_data;
    end else if (tx_valid_q && tx_ready) begin
      tx_valid_q <= 1'b0;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;

`ifdef UART_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_q;

  assign timeout_hit = locked && !own_valid &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!locked || xfer || timeout_hit) cnt_d = '0;
    else if (!own_valid)               cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_sys or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      abort_q <= timeout_hit;
    end
  end

  assign abort = abort_q;
`else
  assign timeout_hit = 1'b0;
  assign abort       = 1'b0;
`endif

endmodule
